// File: rtl/path_replayer_pkg.sv
// Shared constants for the maze path replayer: direction encoding,
// FSM state encoding and default widths.
package path_replayer_pkg;

    localparam int unsigned DEFAULT_COORD_W = 4;
    localparam int unsigned DEFAULT_CNT_W   = 5;
    localparam int unsigned DIR_W           = 2;
    localparam int unsigned STATE_W         = 2;

    // Move encoding as pushed by the solver
    localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b00;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
    localparam logic [DIR_W-1:0] DIR_UP    = 2'b11;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] FIN  = 2'd2;

endpackage

// File: rtl/path_replayer_dir_undo.sv
// Combinational inverse of one solver move: returns the cell the move came from.
module dir_undo
    import path_replayer_pkg::*;
#(
    parameter int unsigned COORD_W = DEFAULT_COORD_W
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [DIR_W-1:0]   dir,
    output logic [COORD_W-1:0] prev_x,
    output logic [COORD_W-1:0] prev_y
);

    // Coordinates wrap modulo the grid size
    always_comb begin
        prev_x = x;
        prev_y = y;
        case (dir)
            DIR_RIGHT: prev_x = x - COORD_W'(1);
            DIR_DOWN:  prev_y = y - COORD_W'(1);
            DIR_LEFT:  prev_x = x + COORD_W'(1);
            DIR_UP:    prev_y = y + COORD_W'(1);
        endcase
    end

endmodule

// File: rtl/path_replayer.sv
// Drains the solver's direction stack after the goal is reached and streams
// the visited cells, goal first, over a valid/ready interface.
module path_replayer
    import path_replayer_pkg::*;
#(
    parameter int unsigned COORD_W = DEFAULT_COORD_W,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    input  logic [1:0]         stack_data,
    input  logic               stack_empty,
    output logic               stack_pop,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   steps
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic [COORD_W-1:0] undo_x;
    logic [COORD_W-1:0] undo_y;
    logic [CNT_W-1:0]   steps_nxt;
    logic               out_valid_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               slot_free;

    dir_undo #(.COORD_W(COORD_W)) u_dir_undo (
        .x      (x_out),
        .y      (y_out),
        .dir    (stack_data),
        .prev_x (undo_x),
        .prev_y (undo_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, next outputs and the combinational pop strobe
    always_comb begin
        state_nxt     = state;
        x_nxt         = x_out;
        y_nxt         = y_out;
        out_valid_nxt = out_valid;
        steps_nxt     = steps;
        stack_pop     = 1'b0;
        slot_free     = !out_valid || out_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    x_nxt         = goal_x;
                    y_nxt         = goal_y;
                    out_valid_nxt = 1'b1;
                    steps_nxt     = '0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (slot_free) begin
                    if (!stack_empty) begin
                        stack_pop     = 1'b1;
                        x_nxt         = undo_x;
                        y_nxt         = undo_y;
                        out_valid_nxt = 1'b1;
                        steps_nxt     = steps + CNT_W'(1);
                    end else begin
                        out_valid_nxt = 1'b0;
                        state_nxt     = FIN;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_out     <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            steps     <= '0;
        end else begin
            x_out     <= x_nxt;
            y_out     <= y_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            steps     <= steps_nxt;
        end
    end

endmodule
